// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//  Shared definitions for the unified instruction/data memory port arbiter.
//  - arb_state_t : arbiter FSM state (IDLE may grant, RD_WAIT holds a read open)
//  - OWN_CPU/LDR : encoding of the master that owns the outstanding read
//  - BE_W        : byte-enable width for the default 32-bit data path
//  - be_width()  : byte-enable width for an arbitrary data width
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BE_W       = DATA_W_DEF / 8;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-port memory between the CPU datapath (m0) and the
//  program-loader/debug master (m1). The CPU has fixed priority; a fairness
//  counter forces a loader grant after MAX_BURST consecutive CPU grants while
//  the loader waits. Reads hold the port for 1+RD_LAT cycles and the returned
//  data is steered to the master that issued the read.
//
//  Parameters
//   ADDR_W     byte address width
//   DATA_W     data width (byte enables are DATA_W/8 wide)
//   RD_LAT     memory read latency in cycles, 1..4
//   MAX_BURST  max consecutive m0 grants while m1 waits, 1..15
//
//  Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   mX_req/we/addr/wdata/be   master X request, held stable until mX_gnt
//   mX_gnt                    one-cycle pulse, request accepted this cycle
//   mX_rvalid, mX_rdata       one-cycle read return; rdata is 0 otherwise
//   mem_en/we/addr/wdata/be   memory access strobe and command
//   mem_rdata                 memory read data, valid RD_LAT cycles after mem_en
//   busy                      a read is outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  busy
);

  // Parameter legality is checked at elaboration.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mem_port_arbiter: MAX_BURST must be in 1..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mem_port_arbiter: DATA_W must be a multiple of 8");
  end

  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);
  localparam logic [3:0] FAIR_MAX  = 4'(MAX_BURST);

  arb_state_t state, state_d;
  logic       owner, owner_d;
  logic [2:0] lat_cnt, lat_cnt_d;
  logic [3:0] fair_cnt, fair_cnt_d;

  logic       win_ldr;
  logic       sel_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_CPU;
      lat_cnt  <= '0;
      fair_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      lat_cnt  <= lat_cnt_d;
      fair_cnt <= fair_cnt_d;
    end
  end

  // The loader wins only when the CPU is idle or has used up its burst.
  assign win_ldr = m1_req && (!m0_req || (fair_cnt == FAIR_MAX));
  assign sel_we  = win_ldr ? m1_we : m0_we;

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    lat_cnt_d  = lat_cnt;
    fair_cnt_d = fair_cnt;

    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    busy       = 1'b0;

    // Outputs are combinational on the requests, so they are forced quiet
    // while reset is held rather than relying on the flops alone.
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            mem_en = 1'b1;
            mem_we = sel_we;
            if (win_ldr) begin
              m1_gnt    = 1'b1;
              mem_addr  = m1_addr;
              mem_wdata = m1_wdata;
              mem_be    = m1_be;
            end else begin
              m0_gnt    = 1'b1;
              mem_addr  = m0_addr;
              mem_wdata = m0_wdata;
              mem_be    = m0_be;
            end
            if (!sel_we) begin
              owner_d   = win_ldr ? OWN_LDR : OWN_CPU;
              lat_cnt_d = LAT_INIT;
              state_d   = ST_RD_WAIT;
            end
          end
        end

        ST_RD_WAIT: begin
          busy      = 1'b1;
          lat_cnt_d = lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (owner == OWN_LDR) begin
              m1_rvalid = 1'b1;
              m1_rdata  = mem_rdata;
            end else begin
              m0_rvalid = 1'b1;
              m0_rdata  = mem_rdata;
            end
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (!m1_req || m1_gnt) begin
        fair_cnt_d = '0;
      end else if (m0_gnt && (fair_cnt != FAIR_MAX)) begin
        fair_cnt_d = fair_cnt + 4'd1;
      end
    end
  end

endmodule
